// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue queue and the downstream operation demultiplexer.
//   alu_op_t    - 4-bit opcode enum (nine legal operations)
//   alu_req_t   - packed request {op, data}, ALU_BUS_W bits wide
//   is_legal_op - true for opcodes the ALU implements
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpMp  = 4'd2,
        OpSll = 4'd3,
        OpSrl = 4'd4,
        OpAnd = 4'd5,
        OpOr  = 4'd6,
        OpXor = 4'd7,
        OpInv = 4'd8
    } alu_op_t;

    localparam logic [3:0]  ALU_OP_LAST = 4'd8;
    localparam int unsigned ALU_BUS_W   = 36;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] data;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous FIFO of alu_req_t entries.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, wdata_i    - enqueue request (ignored when full)
//   pop_i, rdata_o     - dequeue request; rdata_o is the head entry
//   full_o, empty_o    - occupancy flags
//   count_o            - number of stored entries
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  alu_req_t                wdata_i,
    input  logic                    pop_i,
    output alu_req_t                rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    alu_req_t    mem_q [DEPTH];
    alu_req_t    mem_d [DEPTH];
    // Last entry popped; presented while empty so the bus holds its value.
    alu_req_t    last_q, last_d;
    alu_req_t    head;
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign rdata_o = empty_o ? last_q : head;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            last_d   = head;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: it is never observed until written.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffered issue stage ahead of the ALU operation demultiplexer.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - request handshake; in_op/in_data carry the request
//   out_valid/out_ready   - head-of-queue handshake; out_bus = {op, data}
//   count                 - queue occupancy
//   err_pulse, err_cnt    - one-cycle flag and saturating count of dropped illegal opcodes
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [31:0]             in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ALU_BUS_W-1:0]    out_bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_pulse,
    output logic [ERR_W-1:0]        err_cnt
);

    logic       full, empty;
    logic       accept, legal, push, drop, pop;
    alu_req_t   wreq, head;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal_op(in_op);
    assign push      = accept && legal;
    assign drop      = accept && !legal;
    assign pop       = out_valid && out_ready;
    assign wreq      = '{op: alu_op_t'(in_op), data: in_data};
    assign out_bus   = head;

    alu_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (wreq),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        err_pulse_d = drop;
        err_cnt_d   = err_cnt_q;
        if (drop && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed checks of alu_issue_queue plus a model-checked mixed-traffic run.
module tb_alu_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ERR_W = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_bus;
    logic [2:0]  count;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [35:0] model_q[$];
    int unsigned err_model;
    logic        m_pop, m_acc;

    alu_issue_queue #(
        .DEPTH (DEPTH),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bus   (out_bus),
        .count     (count),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Outputs are sampled and inputs changed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        err_model = 0;
        #23;
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bus",   64'(out_bus),   64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_err_cnt",   64'(err_cnt),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // Single ADD, one-cycle latency, then drains
        in_valid  = 1'b1;
        in_op     = 4'h0;
        in_data   = 32'h0000_0005;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_out_bus",   64'(out_bus),   64'h0_0000_0005);
        check("lat_count",     64'(count),     64'd1);
        step();
        check("lat_drop_valid", 64'(out_valid), 64'd0);
        check("lat_drop_count", 64'(count),     64'd0);

        // Fill under back-pressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("fill_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_op    = 4'h1;
            in_data  = 32'(i);
            step();
        end
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_data = 32'd5;
        step();
        check("full_hold_count", 64'(count),   64'd4);
        check("full_hold_bus",   64'(out_bus), 64'h1_0000_0001);

        // Full with pop: no push this cycle, push lands next cycle
        out_ready = 1'b1;
        step();
        check("fp_count",    64'(count),    64'd3);
        check("fp_in_ready", 64'(in_ready), 64'd1);
        check("fp_bus2",     64'(out_bus),  64'h1_0000_0002);
        step();
        in_valid = 1'b0;
        check("fp_push_count", 64'(count),   64'd3);
        check("drain_bus3",    64'(out_bus), 64'h1_0000_0003);
        step();
        check("drain_bus4", 64'(out_bus), 64'h1_0000_0004);
        step();
        check("drain_bus5", 64'(out_bus), 64'h1_0000_0005);
        step();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_count", 64'(count),     64'd0);

        // Illegal opcode dropped
        in_valid = 1'b1;
        in_op    = 4'hA;
        in_data  = 32'hDEAD_BEEF;
        check("ill_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("ill_err_pulse", 64'(err_pulse), 64'd1);
        check("ill_err_cnt",   64'(err_cnt),   64'd1);
        check("ill_out_valid", 64'(out_valid), 64'd0);
        check("ill_count",     64'(count),     64'd0);
        step();
        check("ill_pulse_off", 64'(err_pulse), 64'd0);
        check("ill_cnt_hold",  64'(err_cnt),   64'd1);
        err_model = 1;

        // Mixed traffic against a queue model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = ($urandom_range(0, 9) == 0) ? 4'(9 + $urandom_range(0, 6))
                                                    : 4'($urandom_range(0, 8));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            check("mix_in_ready",  64'(in_ready),  64'(model_q.size() < DEPTH));
            check("mix_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            check("mix_count",     64'(count),     64'(model_q.size()));
            check("mix_err_cnt",   64'(err_cnt),   64'(err_model));
            if (model_q.size() != 0) check("mix_out_bus", 64'(out_bus), 64'(model_q[0]));
            m_pop = out_ready && (model_q.size() != 0);
            m_acc = in_valid && (model_q.size() < DEPTH);
            if (m_pop) void'(model_q.pop_front());
            if (m_acc && in_op <= 4'd8) model_q.push_back({in_op, in_data});
            else if (m_acc && err_model < 255) err_model++;
            step();
        end

        // Drain, then saturate the error counter
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) step();
        model_q.delete();
        check("pre_sat_count", 64'(count), 64'd0);
        in_valid = 1'b1;
        in_op    = 4'hF;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
        check("sat_err_cnt",   64'(err_cnt),   64'd255);
        check("sat_err_pulse", 64'(err_pulse), 64'd1);
        check("sat_out_valid", 64'(out_valid), 64'd0);
        step();
        check("sat_pulse_off", 64'(err_pulse), 64'd0);
        check("sat_cnt_hold",  64'(err_cnt),   64'd255);

        // Asynchronous reset flushes queued entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'h7;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'(100 + i);
            step();
        end
        in_valid = 1'b0;
        check("flush_pre_count", 64'(count),     64'd3);
        check("flush_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_count",     64'(count),     64'd0);
        check("flush_err_cnt",   64'(err_cnt),   64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        #10;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_bus",   64'(out_bus),   64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Buffered issue stage directly upstream of the ALU operation demultiplexer. It accepts ALU requests (4-bit opcode plus 32-bit operand) over a valid/ready handshake and screens out illegal opcodes. Legal requests are held in a small FIFO. The oldest legal request is presented as the packed 36-bit bus the demultiplexer consumes. Downstream back-pressure is absorbed without losing or duplicating requests.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ERR_W, 8: width of the illegal-opcode counter.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  request can be taken this cycle.
- in_op  in  4  opcode (alu_op_t).
- in_data  in  32  operand.
- out_valid  out  1  out_bus holds a valid request.
- out_ready  in  1  downstream consumes out_bus this cycle.
- out_bus  out  36  packed request: [35:32] = opcode, [31:0] = operand.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_pulse  out  1  high for one cycle after an illegal opcode is dropped.
- err_cnt  out  ERR_W  number of dropped requests; saturates at its maximum.

## Operation
- Legal opcodes, 0 to 8: ADD=0, SUB=1, MP=2, SLL=3, SRL=4, AND=5, OR=6, XOR=7, INV=8.
- Illegal opcodes, 9 to 15:
  - Handshake completes normally (accepted whenever in_ready is high).
  - Request is not enqueued.
  - err_pulse and err_cnt update.
- Push: in_valid && in_ready && legal opcode.
- Pop: out_valid && out_ready.
- in_ready = !full (registered occupancy); it does not depend on out_ready in the same cycle.
- out_valid = !empty.
- out_bus = {head.op, head.data}, driven from a register or FIFO storage with no combinational path from the in_* ports.
- When empty, out_bus holds its last value. The bench ignores out_bus while out_valid is low.
- Simultaneous push and pop:
  - Allowed in any non-full state.
  - Occupancy is unchanged.
  - Order is preserved.
- Full with pop in the same cycle: in_ready stays low that cycle, so no push occurs. Next cycle in_ready=1.
- Strict FIFO order. Each legal request appears exactly once on out_bus.
- err_cnt saturates at 2^ERR_W-1. err_pulse still fires when the counter is saturated.
- Pointer wrap: read and write pointers are $clog2(DEPTH)+1 bits. Full/empty come from MSB comparison, so there is no off-by-one at wrap.

## Timing
- Reset values: out_valid=0, out_bus=0, count=0, err_pulse=0, err_cnt=0, in_ready=1 after reset release.
- Reset asserted mid-operation flushes the FIFO immediately, asynchronously. All in-flight requests are discarded.
- Latency: a request accepted at edge N is visible on out_bus with out_valid=1 after edge N (cycle N+1), provided the FIFO was empty.
- Throughput: one request per cycle sustained while out_ready=1.
- count updates on the edge of each push/pop.
- err_pulse is registered: high in the cycle after the dropping handshake.
- out_bus and out_valid are stable while out_valid && !out_ready. Downstream may sample late.

## Structure
- Shared package alu_pkg:
  - alu_op_t: 4-bit enum holding the nine opcodes.
  - ALU_OP_LAST = 4'd8.
  - ALU_BUS_W = 36.
  - alu_req_t packed struct {op, data}.
- The downstream demultiplexer uses the same package.
- Natural sub-module: alu_req_fifo, a generic synchronous FIFO over alu_req_t.
- Top level holds the legality check, error counter and handshake glue.

## Test plan
- Reset, then push op=0 (ADD), data=32'h0000_0005 with out_ready=1:
  - out_valid=1 in the next cycle with out_bus=36'h0_0000_0005.
  - out_valid drops the cycle after that.
- Hold out_ready=0 and push five legal requests:
  - First four accepted; count=4; in_ready=0 on the fifth.
  - Release out_ready; data drains in order 1, 2, 3, 4; then the fifth is accepted.
- Push op=4'hA, data=32'hDEAD_BEEF:
  - Handshake completes and nothing reaches out_bus.
  - err_pulse=1 for one cycle; err_cnt=1.
- Full FIFO with in_valid=1 and out_ready=1 for one cycle:
  - Pop occurs; count=3; no push that cycle.
  - Push lands on the next cycle.
- Random valid/ready toggling for 10k requests (about 10% illegal):
  - Scoreboard matches order and contents.
  - err_cnt saturates at 255 once ≥255 illegal requests have been sent.
- Assert rst_n with three entries queued: out_valid=0 and count=0 immediately, without waiting for a clock edge.
